// File: rtl/oursring_sd_bridge.sv
// Debug-port to ring bridge: one request in flight, converts debug read/write
// requests into ring transactions and returns a single debug response. A ring
// response that arrives after the bridge gave up is drained before the next
// debug request is accepted, so late data can never be mistaken for a new reply.

package oursring_sd_pkg;
  localparam logic [1:0] ST_RD  = 2'd0;
  localparam logic [1:0] ST_WR  = 2'd1;
  localparam logic [1:0] ST_RSP = 2'd2;
  localparam logic [1:0] ST_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  typ;
    logic [39:0] addr;
    logic [63:0] data;
  } sd_info_t;
endpackage

module oursring_sd_bridge
  import oursring_sd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sd_req_valid,
  output logic        sd_req_ready,
  input  sd_info_t    sd_req_info,
  output logic        ring_req_valid,
  input  logic        ring_req_ready,
  output logic        ring_req_wr,
  output logic [39:0] ring_req_addr,
  output logic [63:0] ring_req_wdata,
  input  logic        ring_rsp_valid,
  output logic        ring_rsp_ready,
  input  logic        ring_rsp_err,
  input  logic [63:0] ring_rsp_rdata,
  output logic        sd_rsp_valid,
  input  logic        sd_rsp_ready,
  output sd_info_t    sd_rsp_info
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DR_OUT,
    ST_INDIRECT_IN,
    ST_INDIRECT_OUT
  } st_state_e;

  st_state_e   r_state;
  logic        r_stale;
  logic [15:0] r_cnt;
  logic        r_sd_req_ready;
  logic        r_ring_req_valid;
  logic        r_ring_req_wr;
  logic [39:0] r_ring_req_addr;
  logic [63:0] r_ring_req_wdata;
  logic        r_ring_rsp_ready;
  logic        r_sd_rsp_valid;
  sd_info_t    r_sd_rsp_info;

  logic        w_req_hs;
  logic        w_rsp_hs;
  logic        w_timeout;
  logic        w_ring_typ;
  logic [15:0] w_cnt_inc;

  // Handshakes use the registered readies, so inputs never reach outputs combinationally.
  assign w_req_hs   = sd_req_valid && r_sd_req_ready;
  assign w_rsp_hs   = ring_rsp_valid && r_ring_rsp_ready;
  assign w_timeout  = (TIMEOUT != 16'd0) && (r_cnt == TIMEOUT - 16'd1);
  assign w_ring_typ = (sd_req_info.typ == ST_RD) || (sd_req_info.typ == ST_WR);
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Bridge FSM; every handshake output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= ST_IDLE;
      r_stale          <= 1'b0;
      r_cnt            <= 16'd0;
      r_sd_req_ready   <= 1'b0;
      r_ring_req_valid <= 1'b0;
      r_ring_req_wr    <= 1'b0;
      r_ring_req_addr  <= 40'd0;
      r_ring_req_wdata <= 64'd0;
      r_ring_rsp_ready <= 1'b0;
      r_sd_rsp_valid   <= 1'b0;
      r_sd_rsp_info    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Readies settle from stale here, which also covers the first cycle after reset.
          r_sd_req_ready   <= ~r_stale;
          r_ring_rsp_ready <= r_stale;
          r_cnt            <= w_cnt_inc;
          if (w_req_hs) begin
            r_sd_req_ready <= 1'b0;
            if (w_ring_typ) begin
              r_state          <= ST_DR_OUT;
              r_ring_req_valid <= 1'b1;
              r_ring_req_wr    <= (sd_req_info.typ == ST_WR);
              r_ring_req_addr  <= sd_req_info.addr;
              r_ring_req_wdata <= (sd_req_info.typ == ST_WR) ? sd_req_info.data : 64'd0;
            end else begin
              // A response-typed request is bounced straight back as an error.
              r_state        <= ST_INDIRECT_OUT;
              r_sd_rsp_valid <= 1'b1;
              r_sd_rsp_info  <= {ST_ERR, sd_req_info.addr, 64'd0};
            end
          end else if (r_stale && (w_rsp_hs || w_timeout)) begin
            // Late response drained, or waited long enough that none is coming.
            r_stale          <= 1'b0;
            r_ring_rsp_ready <= 1'b0;
            r_sd_req_ready   <= 1'b1;
          end
        end
        ST_DR_OUT: begin
          if (ring_req_ready) begin
            r_state          <= ST_INDIRECT_IN;
            r_ring_req_valid <= 1'b0;
            r_ring_rsp_ready <= 1'b1;
            r_cnt            <= 16'd0;
          end
        end
        ST_INDIRECT_IN: begin
          if (w_rsp_hs) begin
            // A response landing on the timeout cycle still wins.
            r_state          <= ST_INDIRECT_OUT;
            r_ring_rsp_ready <= 1'b0;
            r_sd_rsp_valid   <= 1'b1;
            r_sd_rsp_info    <= {ring_rsp_err ? ST_ERR : ST_RSP, r_ring_req_addr,
                                 (ring_rsp_err || r_ring_req_wr) ? 64'd0 : ring_rsp_rdata};
          end else if (w_timeout) begin
            r_state          <= ST_INDIRECT_OUT;
            r_stale          <= 1'b1;
            r_ring_rsp_ready <= 1'b0;
            r_sd_rsp_valid   <= 1'b1;
            r_sd_rsp_info    <= {ST_ERR, r_ring_req_addr, 64'hDEAD_DEAD_DEAD_DEAD};
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_INDIRECT_OUT: begin
          if (sd_rsp_ready) begin
            r_state          <= ST_IDLE;
            r_sd_rsp_valid   <= 1'b0;
            r_cnt            <= 16'd0;
            r_ring_rsp_ready <= r_stale;
            r_sd_req_ready   <= ~r_stale;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sd_req_ready   = r_sd_req_ready;
  assign ring_req_valid = r_ring_req_valid;
  assign ring_req_wr    = r_ring_req_wr;
  assign ring_req_addr  = r_ring_req_addr;
  assign ring_req_wdata = r_ring_req_wdata;
  assign ring_rsp_ready = r_ring_rsp_ready;
  assign sd_rsp_valid   = r_sd_rsp_valid;
  assign sd_rsp_info    = r_sd_rsp_info;

endmodule

// File: doc/oursring_sd_bridge.md
OURSRING_SD_BRIDGE -- requirements
Module: oursring_sd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000: cycles to wait for a ring response; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on the rising edge.
REQ-003 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port sd_req_valid, input, 1: debug-side request valid.
REQ-005 SHALL have port sd_req_ready, output, 1: debug-side request accepted.
REQ-006 SHALL have port sd_req_info, input, sd_info_t (106 bits: typ[105:104], addr[103:64], data[63:0]): request payload.
REQ-007 SHALL have port ring_req_valid, output, 1: ring request valid.
REQ-008 SHALL have port ring_req_ready, input, 1: ring accepts the request.
REQ-009 SHALL have port ring_req_wr, output, 1: 1 = write, 0 = read.
REQ-010 SHALL have port ring_req_addr, output, 40: ring address.
REQ-011 SHALL have port ring_req_wdata, output, 64: write data.
REQ-012 SHALL have port ring_rsp_valid, input, 1: ring response valid.
REQ-013 SHALL have port ring_rsp_ready, output, 1: response accepted.
REQ-014 SHALL have port ring_rsp_err, input, 1: response carries an error.
REQ-015 SHALL have port ring_rsp_rdata, input, 64: read data.
REQ-016 SHALL have port sd_rsp_valid, output, 1: debug-side response valid.
REQ-017 SHALL have port sd_rsp_ready, input, 1: debug side accepts the response.
REQ-018 SHALL have port sd_rsp_info, output, sd_info_t: response payload.

Function
REQ-019 SHALL implement an FSM with states typed st_state_e: ST_IDLE, ST_DR_OUT (drive ring request), ST_INDIRECT_IN (await ring response), ST_INDIRECT_OUT (present debug response); one transaction outstanding.
REQ-020 SHALL drive sd_req_ready = 1 only in ST_IDLE with stale = 0.
REQ-021 SHALL latch sd_req_info on sd_req_valid && sd_req_ready; typ ST_RD/ST_WR -> ST_DR_OUT; typ ST_RSP/ST_ERR -> ST_INDIRECT_OUT with {ST_ERR, latched addr, 64'h0}, no ring access.
REQ-022 SHALL hold ring_req_valid = 1 with stable wr/addr/wdata throughout ST_DR_OUT; on ring_req_ready go to ST_INDIRECT_IN and clear the timeout counter; ring_req_wdata = 0 for reads.
REQ-023 SHALL drive ring_rsp_ready = 1 in ST_INDIRECT_IN, and in ST_IDLE while stale = 1; 0 otherwise.
REQ-024 SHALL, on a response handshake in ST_INDIRECT_IN, form sd_rsp_info = {ring_rsp_err ? ST_ERR : ST_RSP, latched addr, err ? 64'h0 : (read ? ring_rsp_rdata : 64'h0)} and go to ST_INDIRECT_OUT.
REQ-025 SHALL count cycles in ST_INDIRECT_IN with a 16-bit saturating counter; when TIMEOUT != 0 and the count reaches TIMEOUT-1 with no response, produce {ST_ERR, addr, 64'hDEAD_DEAD_DEAD_DEAD}, set stale = 1, and go to ST_INDIRECT_OUT.
REQ-026 SHALL, when the response handshake and the timeout occur in the same cycle, take the response and leave stale unchanged.
REQ-027 SHALL hold sd_rsp_valid = 1 with stable sd_rsp_info in ST_INDIRECT_OUT; on sd_rsp_ready go to ST_IDLE.
REQ-028 SHALL clear stale when a response is drained in ST_IDLE, or after TIMEOUT further cycles in ST_IDLE, counted by the same counter restarted on entry to ST_IDLE.
REQ-029 SHALL drive all outputs from registers or from the state decode only, with no combinational path from any input to any output.

Reset
REQ-030 SHALL, while rstn = 0, force state = ST_IDLE, stale = 0, counter = 0, sd_rsp_info = 0, and ring_req_addr/wdata/wr = 0.
REQ-031 SHALL hold sd_req_ready, ring_req_valid, ring_rsp_ready and sd_rsp_valid at 0 while rstn = 0.
REQ-032 SHALL treat reset asserted mid-transaction as an abort: the transaction is dropped and no response is produced after reset.

Verification
REQ-033 SHALL pass: read at addr 40'h12_3456_7890, ring returns rdata 64'hA5A5 with err = 0 -> sd_rsp_info = {ST_RSP, 40'h12_3456_7890, 64'hA5A5}.
REQ-034 SHALL pass: write with data 64'h55 and ring_req_ready held low 5 cycles -> request fields stable for all 6 cycles, then sd_rsp_info = {ST_RSP, addr, 64'h0}.
REQ-035 SHALL pass: request with typ = ST_RSP -> ring_req_valid never asserts and sd_rsp_info.typ = ST_ERR.
REQ-036 SHALL pass: TIMEOUT = 8 with no ring response -> ST_ERR with data 64'hDEAD_DEAD_DEAD_DEAD after 8 cycles in ST_INDIRECT_IN; sd_req_ready stays 0 until the late response is drained.
REQ-037 SHALL pass: ring error response -> sd_rsp_info = {ST_ERR, addr, 64'h0}; sd_rsp_ready held low 3 cycles -> payload stable.
REQ-038 SHALL pass: rstn pulsed low while in ST_INDIRECT_IN -> all outputs 0 within the reset and state = ST_IDLE after release.
